writeback_queue: RTL
====================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two, 2 or more.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port in_valid_i, input, 1, producer result valid.
REQ-007 The block SHALL have port in_ready_o, output, 1, queue can accept a result this cycle.
REQ-008 The block SHALL have port in_addr_i, input, ADDR_WIDTH, destination register.
REQ-009 The block SHALL have port in_data_i, input, DATA_WIDTH, result value.
REQ-010 The block SHALL have port wr_stall_i, input, 1, register-file write port unavailable this cycle.
REQ-011 The block SHALL have port RegWrite_o, output, 1, write strobe to the register file.
REQ-012 The block SHALL have port write_addr_o, output, ADDR_WIDTH, register-file write address.
REQ-013 The block SHALL have port write_data_o, output, DATA_WIDTH, register-file write data.
REQ-014 The block SHALL have port lookup_addr_i, input, ADDR_WIDTH, source register queried by decode.
REQ-015 The block SHALL have port lookup_hit_o, output, 1, a queued entry targets lookup_addr_i.
REQ-016 The block SHALL have port lookup_data_o, output, DATA_WIDTH, forwarded value of youngest matching entry.
REQ-017 The block SHALL have port count_o, output, $clog2(DEPTH+1), number of occupied entries.

Function
REQ-018 The block SHALL behave as an in-order FIFO: enqueue on in_valid_i and in_ready_o in the same cycle; accepted entry is visible at the head no earlier than the next cycle.
REQ-019 in_ready_o SHALL be high exactly when count_o < DEPTH; a full queue SHALL NOT accept, even if a dequeue occurs in the same cycle.
REQ-020 An accepted result with in_addr_i == 0 SHALL be discarded (not stored, count unchanged), preserving x0 == 0.
REQ-021 RegWrite_o SHALL be high exactly when count_o != 0 and wr_stall_i is low; write_addr_o/write_data_o SHALL present the head entry combinationally.
REQ-022 When RegWrite_o is high the head entry SHALL be dequeued at that rising edge; the register file always accepts.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count_o unchanged and preserve order.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-025 Lookup SHALL be combinational over stored entries only (not the same-cycle enqueue); lookup_addr_i == 0 SHALL give lookup_hit_o = 0.
REQ-026 With multiple matches, the youngest (most recently enqueued) entry SHALL win.
REQ-027 When empty or no match, lookup_hit_o SHALL be 0 and lookup_data_o SHALL be 0.

Reset
REQ-028 While rst is high at a rising edge, pointers and count SHALL clear to 0, so RegWrite_o = 0, in_ready_o = 1, lookup_hit_o = 0 from the next cycle; storage contents need not be reset.
REQ-029 Reset mid-operation SHALL discard all pending entries without generating any write; inputs during the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro WBQ_FORWARD_EN SHALL, when defined, enable forwarding per REQ-025..027.
REQ-031 When WBQ_FORWARD_EN is undefined, lookup_hit_o SHALL still report matches (stall indication), and lookup_data_o SHALL be tied to 0.

Structure
REQ-032 Package wbq_pkg SHALL hold typedef wb_entry_t {addr, data} and default width/depth constants.
REQ-033 The youngest-match priority search SHALL be a sub-module named wbq_lookup.

Verification
REQ-034 Reset, then enqueue (addr 5, 0xDEADBEEF) -> next cycle RegWrite_o=1, write_addr_o=5, write_data_o=0xDEADBEEF; count_o returns to 0.
REQ-035 wr_stall_i=1, enqueue 4 results -> count_o=4, in_ready_o=0; 5th offered is not accepted; release stall -> 4 writes in order, one per cycle.
REQ-036 Enqueue addr 0 data 0x1234 -> never written; count_o stays 0.
REQ-037 Stall; enqueue (3, 0x11) then (3, 0x22); lookup_addr_i=3 -> lookup_hit_o=1, lookup_data_o=0x22 (0 with WBQ_FORWARD_EN undefined).
REQ-038 Continuous enqueue/dequeue for 3*DEPTH results with wrap -> output sequence equals input sequence.
REQ-039 Assert rst with 3 entries queued -> no RegWrite_o pulse afterward; count_o=0, in_ready_o=1.

Source files
------------

// File: rtl/wbq_pkg.sv
// Shared types and default sizing for the writeback queue.
// The WBQ_FORWARD_EN macro (see writeback_queue.sv) selects whether lookup data is forwarded.
package wbq_pkg;

    localparam int WBQ_ADDR_WIDTH = 5;
    localparam int WBQ_DATA_WIDTH = 32;
    localparam int WBQ_DEPTH      = 4;

    typedef struct packed {
        logic [WBQ_ADDR_WIDTH-1:0] addr;
        logic [WBQ_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the occupied entries of the writeback queue.
// Entries are scanned oldest to youngest so that a later match overrides an earlier one.
module wbq_lookup
    import wbq_pkg::*;
#(
    parameter int ADDR_WIDTH = WBQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBQ_DATA_WIDTH,
    parameter int DEPTH      = WBQ_DEPTH,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] datas_i,
    input  logic [PTR_W-1:0]                 rd_ptr_i,
    input  logic [CNT_W-1:0]                 count_i,
    input  logic [ADDR_WIDTH-1:0]            lookup_addr_i,
    output logic                             hit_o,
    output logic [DATA_WIDTH-1:0]            data_o
);

    logic [PTR_W-1:0] idx_s;

    // Priority search keyed by age offset from the read pointer; x0 never matches.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx_s  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) && (lookup_addr_i != '0) &&
                (addrs_i[idx_s] == lookup_addr_i)) begin
                hit_o  = 1'b1;
                data_o = datas_i[idx_s];
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO in front of the register-file write port, with lookup.
// Define WBQ_FORWARD_EN to forward the youngest matching value on lookup_data_o.
module writeback_queue
    import wbq_pkg::*;
#(
    parameter int ADDR_WIDTH = WBQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBQ_DATA_WIDTH,
    parameter int DEPTH      = WBQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [ADDR_WIDTH-1:0]        in_addr_i,
    input  logic [DATA_WIDTH-1:0]        in_data_i,
    input  logic                         wr_stall_i,
    output logic                         RegWrite_o,
    output logic [ADDR_WIDTH-1:0]        write_addr_o,
    output logic [DATA_WIDTH-1:0]        write_data_o,
    input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
    output logic                         lookup_hit_o,
    output logic [DATA_WIDTH-1:0]        lookup_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

    logic                  push_s;
    logic                  pop_s;
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;

    // Handshake and pointer/count update; a full queue refuses even when draining.
    always_comb begin
        in_ready_o = (count_q < CNT_W'(DEPTH));
        push_s     = in_valid_i && in_ready_o && (in_addr_i != '0) && !rst;
        pop_s      = (count_q != '0) && !wr_stall_i && !rst;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (rst) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                2'b01: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                2'b11: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_q[wr_ptr_q] <= in_addr_i;
            data_q[wr_ptr_q] <= in_data_i;
        end
    end

    wbq_lookup #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_lookup (
        .addrs_i       (addr_q),
        .datas_i       (data_q),
        .rd_ptr_i      (rd_ptr_q),
        .count_i       (count_q),
        .lookup_addr_i (lookup_addr_i),
        .hit_o         (fwd_hit_s),
        .data_o        (fwd_data_s)
    );

    // Write port and lookup outputs.
    always_comb begin
        RegWrite_o   = pop_s;
        write_addr_o = addr_q[rd_ptr_q];
        write_data_o = data_q[rd_ptr_q];
        count_o      = count_q;
        lookup_hit_o = fwd_hit_s;
`ifdef WBQ_FORWARD_EN
        lookup_data_o = fwd_data_s;
`else
        lookup_data_o = '0;
`endif
    end

endmodule
